// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF input synchroniser, 3-sample majority vote per bit,
// false-start rejection, optional parity and 1/2 stop bits, valid/ready output with overrun.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int N_W   = 4;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(OVERSAMPLE - 3);
  localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(OVERSAMPLE - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  localparam logic [N_W-1:0] N_ONE       = N_W'(1);
  localparam logic [N_W-1:0] N_DATA_LAST = N_W'(DATA_BITS - 1);
  localparam logic [N_W-1:0] N_STOP_LAST = N_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [N_W-1:0]       n, n_nxt;
  logic [1:0]           votes, votes_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 bit_val;
  logic                 load;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd parity wants an odd count of ones over payload plus parity bit.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic b);
    return (^d ^ b) != (PARITY == 1);
  endfunction

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_nxt     = n;
    votes_nxt = votes;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    load      = 1'b0;
    bit_val   = vote3(votes[1], votes[0], rx_s);
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
          n_nxt     = '0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (cnt == CNT_MID) begin
            cnt_nxt   = '0;
            n_nxt     = '0;
            state_nxt = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      S_DATA, S_PAR, S_STOP: begin
        if (s_tick) begin
          if (cnt == CNT_V0) votes_nxt[1] = rx_s;
          if (cnt == CNT_V1) votes_nxt[0] = rx_s;
          if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + CNT_ONE;
          end else begin
            cnt_nxt = '0;
            n_nxt   = n + N_ONE;
            if (state == S_DATA) begin
              shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
              if (n == N_DATA_LAST) begin
                n_nxt     = '0;
                state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
              end
            end else if (state == S_PAR) begin
              perr_nxt  = parity_bad(shreg, bit_val);
              n_nxt     = '0;
              state_nxt = S_STOP;
            end else begin
              ferr_nxt = ferr | ~bit_val;
              // Return to IDLE mid stop bit so a back-to-back start edge is not missed.
              if (n == N_STOP_LAST) begin
                n_nxt     = '0;
                load      = 1'b1;
                state_nxt = S_IDLE;
              end
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      n          <= '0;
      votes      <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n       <= n_nxt;
      votes   <= votes_nxt;
      shreg   <= shreg_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
      overrun <= load & m_valid & ~m_ready;
      if (load) begin
        m_data     <= shreg;
        parity_err <= perr;
        frame_err  <= ferr_nxt;
        m_valid    <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
